// File: rtl/xccela_ctrl_pkg.sv
// Shared definitions for the Xccela write-path controller: FSM encoding,
// default burst-length width and the registered pad-side beat bundle.
package xccela_ctrl_pkg;

  localparam int XC_LEN_W = 9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_POST = 2'd3;

  typedef struct packed {
    logic [7:0] dq_rise;
    logic [7:0] dq_fall;
    logic       dm_rise;
    logic       dm_fall;
    logic       dqs_rise;
  } pad_beat_t;

  // Pre/postamble counters count down to zero, so they load cycles-1.
  function automatic logic [1:0] pp_load(input int cycles);
    return 2'(cycles - 1);
  endfunction

endpackage

// File: rtl/xccela_ctrl_wr_dqs_gen.sv
// Write-burst DQS/DQ/DM generator: PRE preamble, one registered beat per
// accepted wdata word, POST postamble; pad DDR primitives live outside.
module xccela_ctrl_wr_dqs_gen
  import xccela_ctrl_pkg::*;
#(
  parameter int LEN_W       = XC_LEN_W,
  parameter int PRE_CYCLES  = 1,
  parameter int POST_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic [15:0]      wdata,
  input  logic [1:0]       wmask,
  input  logic             wvalid,
  output logic             wready,
  output logic [7:0]       dq_rise,
  output logic [7:0]       dq_fall,
  output logic             dm_rise,
  output logic             dm_fall,
  output logic             dqs_rise,
  output logic             dqs_fall,
  output logic             dq_oe,
  output logic             dqs_oe,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam logic [1:0] PRE_LOAD  = pp_load(PRE_CYCLES);
  localparam logic [1:0] POST_LOAD = pp_load(POST_CYCLES);

  logic [1:0]       state, state_nxt;
  logic [LEN_W-1:0] beat_cnt, beat_nxt;
  logic [1:0]       pp_cnt, pp_nxt;
  logic             done_nxt, underrun_nxt;
  logic             accept, start_ok;
  pad_beat_t        pad_q, pad_nxt;

  assign accept   = (state == ST_DATA) && wvalid;
  assign start_ok = (state == ST_IDLE) && start && !abort;

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    pp_nxt    = pp_cnt;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_PRE;
          beat_nxt  = len;
          pp_nxt    = PRE_LOAD;
        end
      end
      ST_PRE: begin
        if (pp_cnt == 2'd0) state_nxt = ST_DATA;
        else                pp_nxt    = pp_cnt - 2'd1;
      end
      ST_DATA: begin
        if (accept) begin
          if (beat_cnt == '0) begin
            state_nxt = ST_POST;
            pp_nxt    = POST_LOAD;
          end else begin
            beat_nxt = beat_cnt - LEN_W'(1);
          end
        end
      end
      ST_POST: begin
        if (pp_cnt == 2'd0) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          pp_nxt = pp_cnt - 2'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Abort wins over everything, including a start seen in IDLE.
    if (abort) begin
      state_nxt = ST_IDLE;
      done_nxt  = 1'b0;
      beat_nxt  = beat_cnt;
      pp_nxt    = '0;
    end
  end

  always_comb begin
    underrun_nxt = underrun;
    if (start_ok)                             underrun_nxt = 1'b0;
    else if ((state == ST_DATA) && !wvalid)   underrun_nxt = 1'b1;
  end

  // Non-beat cycles inside a burst keep dq and mask both bytes with DQS low.
  always_comb begin
    pad_nxt          = pad_q;
    pad_nxt.dm_rise  = 1'b1;
    pad_nxt.dm_fall  = 1'b1;
    pad_nxt.dqs_rise = 1'b0;
    if (state_nxt == ST_IDLE) begin
      pad_nxt = '0;
    end else if (accept) begin
      pad_nxt.dq_rise  = wdata[7:0];
      pad_nxt.dq_fall  = wdata[15:8];
      pad_nxt.dm_rise  = wmask[0];
      pad_nxt.dm_fall  = wmask[1];
      pad_nxt.dqs_rise = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      pp_cnt   <= '0;
      done     <= 1'b0;
      underrun <= 1'b0;
      pad_q    <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
      pp_cnt   <= pp_nxt;
      done     <= done_nxt;
      underrun <= underrun_nxt;
      pad_q    <= pad_nxt;
    end
  end

  assign busy     = (state != ST_IDLE);
  assign wready   = (state == ST_DATA);
  assign dq_oe    = busy;
  assign dqs_oe   = busy;
  assign dq_rise  = pad_q.dq_rise;
  assign dq_fall  = pad_q.dq_fall;
  assign dm_rise  = pad_q.dm_rise;
  assign dm_fall  = pad_q.dm_fall;
  assign dqs_rise = pad_q.dqs_rise;
  assign dqs_fall = 1'b0;

endmodule

// File: tb/tb_xccela_ctrl_wr_dqs_gen.sv
// Bench for xccela_ctrl_wr_dqs_gen: beats accepted by the driver go into a
// scoreboard queue and are matched against DQS-high output cycles.
module tb_xccela_ctrl_wr_dqs_gen;

  localparam int LEN_W = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             abort = 1'b0;
  logic [15:0]      wdata = '0;
  logic [1:0]       wmask = '0;
  logic             wvalid = 1'b0;
  logic             wready;
  logic [7:0]       dq_rise, dq_fall;
  logic             dm_rise, dm_fall, dqs_rise, dqs_fall;
  logic             dq_oe, dqs_oe, busy, done, underrun;

  xccela_ctrl_wr_dqs_gen #(
    .LEN_W      (LEN_W),
    .PRE_CYCLES (1),
    .POST_CYCLES(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .abort   (abort),
    .wdata   (wdata),
    .wmask   (wmask),
    .wvalid  (wvalid),
    .wready  (wready),
    .dq_rise (dq_rise),
    .dq_fall (dq_fall),
    .dm_rise (dm_rise),
    .dm_fall (dm_fall),
    .dqs_rise(dqs_rise),
    .dqs_fall(dqs_fall),
    .dq_oe   (dq_oe),
    .dqs_oe  (dqs_oe),
    .busy    (busy),
    .done    (done),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beat: {dq_rise, dq_fall, dm_rise, dm_fall}
  logic [17:0] sb_q[$];
  logic [17:0] sb_exp;
  bit          sb_en = 1'b1;

  int          n_beats, n_busy, n_wready, n_done, n_gaps;
  bit          had_beat = 1'b0, seen_low = 1'b0, prev_busy = 1'b0;
  logic [7:0]  last_r = '0, last_f = '0;
  logic        last_dmr = 1'b0, last_dmf = 1'b0;

  always @(posedge clk) begin
    #1;
    if (busy)   n_busy++;
    if (wready) n_wready++;
    if (done) begin
      n_done++;
      chk("done_idle_entry", 32'({prev_busy, busy}), 32'(2'b10));
    end
    if (dqs_rise) begin
      n_beats++;
      if (had_beat && seen_low) n_gaps++;
      last_r = dq_rise; last_f = dq_fall; last_dmr = dm_rise; last_dmf = dm_fall;
      if (sb_en) begin
        if (sb_q.size() == 0) chk("extra_beat", 32'(1), 32'(0));
        else begin
          sb_exp = sb_q.pop_front();
          chk("beat_data", 32'({dq_rise, dq_fall, dm_rise, dm_fall, dqs_fall}), 32'({sb_exp, 1'b0}));
        end
      end
      had_beat = 1'b1;
      seen_low = 1'b0;
    end else if (busy && wready && had_beat) begin
      seen_low = 1'b1;
      chk("gap_hold", 32'({dq_rise, dq_fall, dm_rise, dm_fall}), 32'({last_r, last_f, 2'b11}));
    end
    if (!busy) begin
      chk("idle_outs", 32'({dq_oe, dqs_oe, wready, dqs_rise, dqs_fall, dm_rise, dm_fall, dq_rise, dq_fall}), 32'(0));
      had_beat = 1'b0;
      seen_low = 1'b0;
    end
    prev_busy = busy;
  end

  task automatic clr_stats();
    n_beats = 0; n_busy = 0; n_wready = 0; n_done = 0; n_gaps = 0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle.
  task automatic run_burst(input int blen, input int gap_cyc, input int abort_beat,
                           input int busy_len, input logic [15:0] d0, input logic [1:0] m0);
    int k, nb;
    bit fin;
    logic [15:0] d;
    logic [1:0]  m;
    clr_stats();
    start = 1'b1; len = LEN_W'(blen); wvalid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("pre_outs", 32'({dq_oe, dqs_oe, dm_rise, dm_fall, dqs_rise, wready, busy, underrun}), 32'(8'b1111_0010));
    k = 0; nb = 0; fin = 1'b0;
    for (int c = 0; c < blen + 40 && !fin; c++) begin
      if (wready) begin
        k++;
        if (busy_len >= 0 && k == 1) begin
          start = 1'b1; len = LEN_W'(busy_len);
        end
        if (k == gap_cyc) begin
          wvalid = 1'b0;
        end else begin
          d = (nb == 0) ? d0 : 16'($urandom);
          m = (nb == 0) ? m0 : 2'($urandom);
          wdata = d; wmask = m; wvalid = 1'b1;
          if (nb == abort_beat) begin
            abort = 1'b1; start = 1'b1;
          end else begin
            sb_q.push_back({d[7:0], d[15:8], m[0], m[1]});
          end
          nb++;
        end
      end else begin
        wvalid = 1'b0;
      end
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      if (!busy) fin = 1'b1;
    end
    if (!fin) chk("burst_timeout", 32'(0), 32'(1));
    wvalid = 1'b0;
    chk("sb_empty", 32'(sb_q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_outs", 32'({busy, wready, dq_oe, dqs_oe, done, underrun, dm_rise, dm_fall, dqs_rise, dq_rise, dq_fall}), 32'(0));
    rst = 1'b0;

    // len=3 straight burst, start on the first edge after reset release
    run_burst(3, -1, -1, -1, 16'h1234, 2'b00);
    chk("b4_beats", 32'(n_beats), 32'(4));
    chk("b4_wready", 32'(n_wready), 32'(4));
    chk("b4_busy", 32'(n_busy), 32'(6));
    chk("b4_done", 32'(n_done), 32'(1));
    chk("b4_gaps", 32'(n_gaps), 32'(0));

    // wvalid low on second DATA cycle
    run_burst(3, 2, -1, -1, 16'h0F0F, 2'b01);
    chk("gap_beats", 32'(n_beats), 32'(4));
    chk("gap_gaps", 32'(n_gaps), 32'(1));
    chk("gap_wready", 32'(n_wready), 32'(5));
    chk("gap_busy", 32'(n_busy), 32'(7));
    chk("gap_done", 32'(n_done), 32'(1));
    chk("underrun_set", 32'(underrun), 32'(1));
    repeat (3) @(negedge clk);
    chk("underrun_sticky", 32'(underrun), 32'(1));

    // single beat with fixed data; also clears underrun
    run_burst(0, -1, -1, -1, 16'hA55A, 2'b10);
    chk("one_beats", 32'(n_beats), 32'(1));
    chk("one_dq", 32'({last_r, last_f}), 32'(16'h5AA5));
    chk("one_dm", 32'({last_dmr, last_dmf}), 32'(2'b01));
    chk("one_done", 32'(n_done), 32'(1));
    chk("underrun_clr", 32'(underrun), 32'(0));

    // start with len=5 while busy must not extend a len=2 burst
    run_burst(2, -1, -1, 5, 16'hBEEF, 2'b11);
    chk("busy_start_beats", 32'(n_beats), 32'(3));
    chk("busy_start_busy", 32'(n_busy), 32'(5));
    chk("busy_start_done", 32'(n_done), 32'(1));

    // abort (with simultaneous start) on the second beat of len=7
    run_burst(7, -1, 1, -1, 16'hC0DE, 2'b00);
    chk("abort_oe", 32'({dq_oe, dqs_oe, wready, busy}), 32'(0));
    repeat (2) @(negedge clk);
    chk("abort_beats", 32'(n_beats), 32'(1));
    chk("abort_done", 32'(n_done), 32'(0));
    chk("abort_no_start", 32'(busy), 32'(0));

    // asynchronous reset in the middle of DATA
    sb_en = 1'b0;
    clr_stats();
    start = 1'b1; len = LEN_W'(7); wvalid = 1'b1; wdata = 16'h5555; wmask = 2'b00;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_oe", 32'({dq_oe, dqs_oe, dqs_rise}), 32'(3'b111));
    #2 rst = 1'b1;
    #1 chk("rst_async", 32'({busy, wready, dq_oe, dqs_oe, dqs_rise, dm_rise, dm_fall, dq_rise, dq_fall, underrun}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; wvalid = 1'b0;
    clr_stats();
    repeat (4) @(negedge clk);
    chk("rst_no_done", 32'(n_done), 32'(0));
    chk("rst_idle", 32'(busy), 32'(0));
    sb_q.delete();
    sb_en = 1'b1;
    run_burst(1, -1, -1, -1, 16'h7E81, 2'b10);
    chk("post_rst_beats", 32'(n_beats), 32'(2));
    chk("post_rst_done", 32'(n_done), 32'(1));

    // maximum length: 512 beats, no wrap
    run_burst(511, -1, -1, -1, 16'hFFFF, 2'b00);
    chk("max_beats", 32'(n_beats), 32'(512));
    chk("max_wready", 32'(n_wready), 32'(512));
    chk("max_done", 32'(n_done), 32'(1));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
